// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and widths for the sequential divider
package alu_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-and-subtract step on a full-adder chain
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // Shifted remainder is WIDTH+1 bits so a large unsigned divisor never wraps.
    logic [WIDTH:0]   minuend;
    logic [WIDTH-1:0] dvs_n;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   carry;

    assign minuend  = {rem_in, dvd_msb};
    assign dvs_n    = ~dvs;
    assign carry[0] = 1'b1;

    // Ripple subtract: minuend + ~dvs + 1, one full adder per bit.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign diff[i]    = minuend[i] ^ dvs_n[i] ^ carry[i];
            assign carry[i+1] = (minuend[i] & dvs_n[i]) | (carry[i] & (minuend[i] ^ dvs_n[i]));
        end
    endgenerate

    // Top cell subtracts the zero-extended divisor bit (inverted to 1), so its
    // carry-out reduces to an OR. Carry-out set means no borrow.
    assign q_bit   = minuend[WIDTH] | carry[WIDTH];
    assign rem_out = q_bit ? diff : minuend[WIDTH-1:0];

endmodule

// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - multi-cycle signed/unsigned restoring divider with valid/ready handshake
module seq_divider32
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic             OFd
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic             ovf_case;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // abs(MIN) lands on MIN itself, which is the correct unsigned magnitude.
    assign a_abs = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_abs = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_msb (dvd[WIDTH-1]),
        .dvs     (dvs),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // Sign fix-up of the magnitude result, with divide-by-zero and MIN/-1 overrides.
    always_comb begin
        q_fix = (sign_a ^ sign_b) ? (~dvd + 1'b1) : dvd;
        r_fix = sign_a ? (~rem + 1'b1) : rem;
        if (b_zero) begin
            q_fix = '1;
            r_fix = a_orig;
        end else if (ovf_case) begin
            q_fix = MIN_VAL;
            r_fix = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-and-subtract iterations, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            a_orig   <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            b_zero   <= 1'b0;
            ovf_case <= 1'b0;
            Q        <= '0;
            R        <= '0;
            DZ       <= 1'b0;
            OFd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem      <= '0;
                        dvd      <= a_abs;
                        dvs      <= b_abs;
                        a_orig   <= A;
                        sign_a   <= is_signed & A[WIDTH-1];
                        sign_b   <= is_signed & B[WIDTH-1];
                        b_zero   <= (B == '0);
                        ovf_case <= is_signed && (A == MIN_VAL) && (B == '1);
                        count    <= CW'(WIDTH - 1);
                        DZ       <= 1'b0;
                        OFd      <= 1'b0;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    Q   <= q_fix;
                    R   <= r_fix;
                    DZ  <= b_zero;
                    OFd <= ovf_case;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// tb/tb_seq_divider32.sv - scoreboard bench for seq_divider32 with random and directed operations
module tb_seq_divider32;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          is_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  Q;
    logic [W-1:0]  R;
    logic          DZ;
    logic          OFd;

    seq_divider32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .DZ        (DZ),
        .OFd       (OFd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ofd;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   n_issued  = 0;
    int   n_results = 0;
    int   rise_cyc  = 0;
    bit   prev_ov   = 1'b0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dz, input logic ofd);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ofd = ofd; e.acc = 0;
        return e;
    endfunction

    // Reference: plain language-level division, truncating toward zero.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int   sa;
        int   sbv;
        e = mk('0, '0, 1'b0, 1'b0);
        if (b == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else if (!s) begin
            e.q = a / b; e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.ofd = 1'b1;
        end else begin
            sa  = a;
            sbv = b;
            e.q = sa / sbv;
            e.r = sa % sbv;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got Q=%h with empty scoreboard", Q);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_results++;
                    check("Q", Q, e.q);
                    check("R", R, e.r);
                    check("DZ", 32'(DZ), 32'(e.dz));
                    check("OFd", 32'(OFd), 32'(e.ofd));
                    check("latency", 32'(rise_cyc - e.acc), 32'(LAT));
                end
            end
            prev_ov = out_valid;
        end
    end

    // Random consumer back-pressure.
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_e(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int w = 0;
        while (!in_ready && w < 300) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready=%b expected 1", in_ready);
            return;
        end
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        is_signed = s;
        tick();
        e.acc = cyc;
        sb.push_back(e);
        n_issued++;
        in_valid  = 1'b0;
        A         = $urandom;
        B         = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        issue_e(a, b, s, model(a, b, s));
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 600) begin
            tick();
            w++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_Q"}, Q, '0);
        check({tag, "_R"}, R, '0);
        check({tag, "_DZ"}, 32'(DZ), 32'd0);
        check({tag, "_OFd"}, 32'(OFd), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           w;

        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Directed values.
        issue_e(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 1'b0));
        drain();
        issue_e(32'hFFFF_FF9C, 32'd7, 1'b1, mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0));
        issue_e(32'd100, 32'hFFFF_FFF9, 1'b1, mk(32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0));
        drain();
        issue_e(32'h1234, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0));
        issue_e(32'h1234, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0));
        issue_e(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 1'b0, 1'b1));
        issue_e(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, mk(32'd0, 32'h8000_0000, 1'b0, 1'b0));
        drain();

        // Stall the consumer and poke in_valid while busy.
        out_ready = 1'b0;
        issue_e(32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 1'b0, 1'b0));
        repeat (5) tick();
        in_valid = 1'b1; A = 32'd50; B = 32'd5; is_signed = 1'b0;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin
            tick();
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_Q", Q, 32'd333);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            in_valid = (i == 2);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of RUN, then a fresh operation.
        issue(32'hDEAD_BEEF, 32'd5, 1'b0);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        sb.delete();
        n_issued--;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        issue_e(32'hFFFF_FFFF, 32'd1, 1'b0, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0));
        drain();

        // Random operations with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = '1; end
                3: rb = $urandom >> $urandom_range(0, 31);
                4: rb = -W'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            issue(ra, rb, rs);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        check("result_count", 32'(n_results), 32'(n_issued));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
